// File: rtl/parallel_data_pack_if.sv
// Bus bundle for the TX packer: per-lane I/Q sample inputs with valid/ready,
// plus the packed-word valid/ready stream toward the DAC.
interface parallel_data_pack_if #(
   parameter int LANES  = 8,
   parameter int LANE_W = 16
);
   logic [LANES*LANE_W-1:0]   r_data;
   logic [LANES*LANE_W-1:0]   q_data;
   logic [LANES-1:0]          lane_valid;
   logic [LANES-1:0]          lane_ready;
   logic [2*LANES*LANE_W-1:0] m_data;
   logic                      m_valid;
   logic                      m_ready;

   modport master (
      output r_data, q_data, lane_valid, m_ready,
      input  lane_ready, m_data, m_valid
   );

   modport slave (
      input  r_data, q_data, lane_valid, m_ready,
      output lane_ready, m_data, m_valid
   );
endinterface

// File: rtl/parallel_data_pack.sv
// Collects LANES independent I/Q pairs into one parallel word and queues it in
// a 2-entry output buffer; sticky per-lane overflow and partial-word timeout.
//
// state | meaning
// IDLE  | no lane held
// FILL  | some lanes held, timeout counter running
// FULL  | every lane held, waiting for buffer room
module parallel_data_pack #(
   parameter int LANES          = 8,
   parameter int LANE_W         = 16,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                clock,
   input  logic                resetn,
   parallel_data_pack_if.slave bus,
   input  logic                clear,
   output logic [LANES-1:0]    overflow,
   output logic                timeout,
   output logic [31:0]         word_count
);
   localparam int WORD_W = 2*LANES*LANE_W;
   localparam int CNT_W  = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES-1);

   typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;

   state_t                  state;
   logic [LANES-1:0]        held;
   logic [LANES-1:0]        held_nxt;
   logic [LANES-1:0]        cap;
   logic [LANES-1:0]        drop;
   logic [LANES-1:0]        lane_ready;
   logic [LANES*LANE_W-1:0] hold_r;
   logic [LANES*LANE_W-1:0] hold_q;
   logic [CNT_W-1:0]        tmo_cnt;
   logic [WORD_W-1:0]       mem [2];
   logic                    rd_ptr;
   logic                    wr_ptr;
   logic [1:0]              count;
   logic [WORD_W-1:0]       packed_word;
   logic                    pop;
   logic                    room;
   logic                    push;
   logic                    tmo_fire;

   // r_k in the low half and q_k in the high half of each 2*LANE_W slot,
   // matching the receive-side slicer lane map
   always_comb begin
      packed_word = '0;
      for (int k = 0; k < LANES; k++) begin
         packed_word[2*LANE_W*k +: LANE_W]        = hold_r[LANE_W*k +: LANE_W];
         packed_word[2*LANE_W*k+LANE_W +: LANE_W] = hold_q[LANE_W*k +: LANE_W];
      end
   end

   assign bus.m_valid    = (count != 2'd0);
   assign bus.m_data     = mem[rd_ptr];
   assign pop            = bus.m_valid && bus.m_ready;
   assign room           = (count < 2'd2) || pop;
   assign push           = (&held) && room;
   assign lane_ready     = ~held | {LANES{push}};
   assign bus.lane_ready = lane_ready;
   assign cap            = bus.lane_valid & lane_ready;
   assign drop           = bus.lane_valid & ~lane_ready;
   assign tmo_fire       = (state == FILL) && (tmo_cnt == TMO_LAST);
   assign held_nxt       = ((push || tmo_fire) ? '0 : held) | cap;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state   <= IDLE;
         held    <= '0;
         hold_r  <= '0;
         hold_q  <= '0;
         tmo_cnt <= '0;
      end else begin
         held <= held_nxt;
         for (int k = 0; k < LANES; k++) begin
            if (cap[k]) begin
               hold_r[LANE_W*k +: LANE_W] <= bus.r_data[LANE_W*k +: LANE_W];
               hold_q[LANE_W*k +: LANE_W] <= bus.q_data[LANE_W*k +: LANE_W];
            end
         end
         if (held_nxt == '0) begin
            state <= IDLE;
         end else if (&held_nxt) begin
            state <= FULL;
         end else begin
            state <= FILL;
            // a fresh partial set (new entry, after a push, or after a discard) restarts the age
            if (state != FILL || push || tmo_fire)
               tmo_cnt <= '0;
            else
               tmo_cnt <= tmo_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         mem[0] <= '0;
         mem[1] <= '0;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= packed_word;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop)
            rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         overflow   <= '0;
         timeout    <= 1'b0;
         word_count <= '0;
      end else if (clear) begin
         overflow   <= '0;
         timeout    <= 1'b0;
         word_count <= '0;
      end else begin
         overflow <= overflow | drop;
         if (tmo_fire)
            timeout <= 1'b1;
         if (pop)
            word_count <= word_count + 32'd1;
      end
   end
endmodule
